tdt_dm_sync_filt: RTL and testbench
===================================

Name: tdt_dm_sync_filt

Overview:
- Multi-channel, parametrised synchroniser for asynchronous single-bit debug-domain inputs (halt/resume requests, reset status, external debug events).
- Each channel has:
  - an N-stage synchroniser chain;
  - a programmable stability (glitch) filter;
  - a per-channel edge-to-pulse mode.
- Sits at the dst_clk boundary of the debug module. Replaces hand-instantiated 2-flop chains plus ad-hoc edge detectors.

Parameters:
- CH_NUM, 4, number of independent channels (>=1).
- SYNC_NUM, 2, synchroniser stages per channel (>=2).
- FILT_CYC, 0, extra consecutive dst_clk cycles a new synchronised value must persist before acceptance (0 = accept on first cycle).
- FILT_W, 4, filter counter width; FILT_CYC <= 2^FILT_W-1.
- CH_MODE, {CH_NUM{2'b00}}, 2 bits per channel, channel i at [2i+1:2i]:
  - 00 level only;
  - 01 rising pulse;
  - 10 falling pulse;
  - 11 any-edge pulse.

Ports:
- dst_clk  in  1  destination clock.
- dst_rst_b  in  1  asynchronous active-low reset.
- src_in  in  CH_NUM  asynchronous source levels; bit i = channel i.
- dst_clr  in  1  synchronous clear, dst_clk domain.
- dst_level  out  CH_NUM  filtered, synchronised level (registered).
- dst_pulse  out  CH_NUM  one-cycle event pulse per channel (registered).
- dst_pulse_any  out  1  OR of dst_pulse (combinational from registers).

Behaviour:
- Clock and reset: clock dst_clk; reset dst_rst_b, asynchronous, active-low.
- Reset: all sync flops, level registers, filter counters and pulse registers go to 0.
  - dst_level=0, dst_pulse=0, dst_pulse_any=0 while dst_rst_b low and after release until inputs propagate.
  - Assertion mid-operation clears everything immediately. No pulse is generated by reset entry or exit.
- Sync chain, per channel: sync[0]<=src_in[i]; sync[k]<=sync[k-1]. sync_out = sync[SYNC_NUM-1]. No logic between stages.
- Filter, per channel, registers lvl_q and cnt_q:
  - sync_out==lvl_q: cnt_q<=0.
  - sync_out!=lvl_q and cnt_q==FILT_CYC: lvl_q<=sync_out, cnt_q<=0 (accept edge).
  - sync_out!=lvl_q and cnt_q<FILT_CYC: cnt_q<=cnt_q+1.
  - Net effect: a new value is accepted only after sync_out differs from lvl_q on FILT_CYC+1 consecutive edges.
  - A sync_out excursion of <=FILT_CYC cycles is discarded; the counter restarts from 0 on return.
- dst_level = lvl_q.
- Latency: a stable src_in change sampled first at edge E appears on dst_level after edge E+SYNC_NUM+FILT_CYC.
- Pulse: on the accept edge, pulse_q<=1 iff the mode matches:
  - rise: 0->1;
  - fall: 1->0;
  - any: either direction.
  - Otherwise pulse_q<=0.
  - dst_pulse is high exactly one cycle, coincident with the first cycle of the new dst_level value.
  - Mode 00 channels: dst_pulse bit constant 0.
- dst_clr: highest priority, takes effect at the next edge. Clears sync, lvl_q, cnt_q and pulse_q to 0 for all channels. The accept/pulse of that cycle is suppressed.
  - After clr deassertion, a channel whose src_in is high re-synchronises and produces a rising/any pulse, with normal latency.
- Channels are fully independent. Simultaneous accepts on several channels give simultaneous pulses.
- Back-to-back accepts on the same channel: possible only when FILT_CYC=0 and the input toggles every cycle. Each accept produces its own pulse; dst_pulse may stay high on consecutive cycles in any-edge mode.
- Filter counter never exceeds FILT_CYC; no wrap. Parameter legality is checked by an elaboration-time check; an illegal FILT_CYC/FILT_W combination is an elaboration error.

Test Plan:
Bench configuration for all scenarios: CH_NUM=4, SYNC_NUM=2, FILT_CYC=2, CH_MODE={11,10,01,00} (ch3 any, ch2 fall, ch1 rise, ch0 level).
1. Reset release, src_in=4'b0000 for 10 cycles -> dst_level=0, dst_pulse=0, dst_pulse_any=0 throughout.
2. src_in 0->4'b1111, first sampled at edge E -> dst_level=4'b1111 after edge E+4; dst_pulse=4'b1010 for exactly that one cycle; dst_pulse_any=1 that cycle only.
3. From 1111, src_in -> 4'b0000 stable -> dst_level=0 after 4 edges; dst_pulse=4'b1100 for one cycle.
4. Glitch: ch1 src_in high for 2 cycles then low -> dst_level[1] stays 0, no pulse. Same glitch held 3 cycles -> dst_level[1]=1 after edge E+4, dst_pulse[1] for one cycle.
5. src_in=4'b0010 accepted, then dst_clr for one cycle while src_in held -> next edge: dst_level=0, dst_pulse=0 (no fall pulse); after release dst_level[1] returns to 1 with a rising pulse at normal latency.
6. Async reset mid-filter (cnt_q=1 on ch3) -> all outputs 0 immediately. After release, ch3 requires the full SYNC_NUM+FILT_CYC+1 edges before acceptance.

Source files
------------

// File: rtl/tdt_dm_sync_filt_if.sv
// Bus bundle for the debug-module input synchroniser/filter.
// master drives the asynchronous levels and the clear; slave returns the filtered level and the pulses.
interface tdt_dm_sync_filt_if #(
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0] src_in;
  logic              dst_clr;
  logic [CH_NUM-1:0] dst_level;
  logic [CH_NUM-1:0] dst_pulse;
  logic              dst_pulse_any;

  modport master (
    output src_in, dst_clr,
    input  dst_level, dst_pulse, dst_pulse_any
  );

  modport slave (
    input  src_in, dst_clr,
    output dst_level, dst_pulse, dst_pulse_any
  );
endinterface

// File: rtl/tdt_dm_sync_filt.sv
// Multi-channel synchroniser for asynchronous debug inputs.
// Each channel has a flop chain, a stability filter and an optional edge-to-pulse stage.
module tdt_dm_sync_filt_lane #(
  parameter int         SYNC_NUM = 2,
  parameter int         FILT_CYC = 0,
  parameter int         FILT_W   = 4,
  parameter logic [1:0] MODE     = 2'b00
) (
  input  logic dst_clk,
  input  logic dst_rst_b,
  input  logic src_i,
  input  logic clr_i,
  output logic level_o,
  output logic pulse_o
);
  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(FILT_CYC);

  logic [SYNC_NUM-1:0] sync_q, sync_d;
  logic [FILT_W-1:0]   cnt_q, cnt_d;
  logic                lvl_q, lvl_d;
  logic                pulse_q, pulse_d;
  logic                sync_out;

  assign sync_out = sync_q[SYNC_NUM-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_NUM-2:0], src_i};
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clr_i) begin
      // Clear wins over an accept in the same cycle, so no edge is reported.
      sync_d = '0;
      lvl_d  = 1'b0;
      cnt_d  = '0;
    end else if (sync_out == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == FILT_MAX) begin
      lvl_d   = sync_out;
      cnt_d   = '0;
      pulse_d = sync_out ? MODE[0] : MODE[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge dst_clk or negedge dst_rst_b) begin
    if (!dst_rst_b) begin
      sync_q  <= '0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = lvl_q;
  assign pulse_o = pulse_q;
endmodule

module tdt_dm_sync_filt #(
  parameter int                  CH_NUM   = 4,
  parameter int                  SYNC_NUM = 2,
  parameter int                  FILT_CYC = 0,
  parameter int                  FILT_W   = 4,
  parameter logic [2*CH_NUM-1:0] CH_MODE  = '0
) (
  input logic              dst_clk,
  input logic              dst_rst_b,
  tdt_dm_sync_filt_if.slave bus
);
  if (CH_NUM < 1)                      begin : g_bad_ch   $error("CH_NUM must be >= 1");              end
  if (SYNC_NUM < 2)                    begin : g_bad_sync $error("SYNC_NUM must be >= 2");            end
  if (FILT_W < 1)                      begin : g_bad_w    $error("FILT_W must be >= 1");              end
  if (FILT_CYC < 0 || FILT_CYC > (2**FILT_W) - 1)
                                       begin : g_bad_filt $error("FILT_CYC does not fit in FILT_W");  end

  logic [CH_NUM-1:0] level, pulse;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    tdt_dm_sync_filt_lane #(
      .SYNC_NUM (SYNC_NUM),
      .FILT_CYC (FILT_CYC),
      .FILT_W   (FILT_W),
      .MODE     (CH_MODE[2*i +: 2])
    ) u_lane (
      .dst_clk   (dst_clk),
      .dst_rst_b (dst_rst_b),
      .src_i     (bus.src_in[i]),
      .clr_i     (bus.dst_clr),
      .level_o   (level[i]),
      .pulse_o   (pulse[i])
    );
  end

  assign bus.dst_level     = level;
  assign bus.dst_pulse     = pulse;
  assign bus.dst_pulse_any = |pulse;
endmodule

// File: tb/tb_tdt_dm_sync_filt.sv
// Directed bench for tdt_dm_sync_filt: FILT_CYC=2, modes ch3 any, ch2 fall, ch1 rise, ch0 level.
module tb_tdt_dm_sync_filt;
  logic clk = 1'b0;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  tdt_dm_sync_filt_if #(.CH_NUM(4)) bus ();

  tdt_dm_sync_filt #(
    .CH_NUM   (4),
    .SYNC_NUM (2),
    .FILT_CYC (2),
    .FILT_W   (4),
    .CH_MODE  (8'b11_10_01_00)
  ) dut (
    .dst_clk   (clk),
    .dst_rst_b (rst_b),
    .bus       (bus.slave)
  );

  typedef struct {
    logic [3:0] src;
    logic       clr;
    logic [3:0] lvl;
    logic [3:0] pls;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] src, input logic clr, input logic [3:0] lvl,
                     input logic [3:0] pls, input string name, input int rep = 1);
    for (int r = 0; r < rep; r++) vecs.push_back('{src, clr, lvl, pls, name});
  endtask

  task automatic check(input string name, input logic [3:0] lvl, input logic [3:0] pls);
    logic any_exp;
    any_exp = |pls;
    n_cmp++;
    if (bus.dst_level !== lvl || bus.dst_pulse !== pls || bus.dst_pulse_any !== any_exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got level=%b pulse=%b any=%b, want level=%b pulse=%b any=%b",
               name, $time, bus.dst_level, bus.dst_pulse, bus.dst_pulse_any, lvl, pls, any_exp);
    end
  endtask

  // Inputs set here are sampled by the next rising edge; outputs checked 1 unit after it.
  task automatic step(input logic [3:0] src, input logic clr, input logic [3:0] lvl,
                      input logic [3:0] pls, input string name);
    bus.src_in  = src;
    bus.dst_clr = clr;
    @(posedge clk);
    #1;
    check(name, lvl, pls);
  endtask

  initial begin
    rst_b       = 1'b0;
    bus.src_in  = 4'b0000;
    bus.dst_clr = 1'b0;

    // 1: idle after reset
    add(4'h0, 0, 4'h0, 4'h0, "idle", 10);
    // 2: all rise, accept at E+4
    add(4'hF, 0, 4'h0, 4'h0, "rise_wait", 4);
    add(4'hF, 0, 4'hF, 4'hA, "rise_accept");
    add(4'hF, 0, 4'hF, 4'h0, "rise_hold", 2);
    // 3: all fall
    add(4'h0, 0, 4'hF, 4'h0, "fall_wait", 4);
    add(4'h0, 0, 4'h0, 4'hC, "fall_accept");
    add(4'h0, 0, 4'h0, 4'h0, "fall_hold", 2);
    // 4a: 2-cycle glitch on ch1 is discarded
    add(4'h2, 0, 4'h0, 4'h0, "glitch2", 2);
    add(4'h0, 0, 4'h0, 4'h0, "glitch2_gone", 5);
    // 4b: 3-cycle excursion is accepted, then the return low is also filtered in
    add(4'h2, 0, 4'h0, 4'h0, "glitch3", 3);
    add(4'h0, 0, 4'h0, 4'h0, "glitch3_wait");
    add(4'h0, 0, 4'h2, 4'h2, "glitch3_accept");
    add(4'h0, 0, 4'h2, 4'h0, "glitch3_hold", 2);
    add(4'h0, 0, 4'h0, 4'h0, "glitch3_fall");
    add(4'h0, 0, 4'h0, 4'h0, "glitch3_idle");
    // 5: clear while ch1 is high, then re-sync with a fresh rising pulse
    add(4'h2, 0, 4'h0, 4'h0, "pre_clr_wait", 4);
    add(4'h2, 0, 4'h2, 4'h2, "pre_clr_accept");
    add(4'h2, 0, 4'h2, 4'h0, "pre_clr_hold");
    add(4'h2, 1, 4'h0, 4'h0, "clr");
    add(4'h2, 0, 4'h0, 4'h0, "post_clr_wait", 4);
    add(4'h2, 0, 4'h2, 4'h2, "post_clr_accept");
    add(4'h2, 0, 4'h2, 4'h0, "post_clr_hold");

    repeat (3) @(posedge clk);
    #1;
    check("in_reset", 4'h0, 4'h0);
    rst_b = 1'b1;

    foreach (vecs[k]) step(vecs[k].src, vecs[k].clr, vecs[k].lvl, vecs[k].pls, vecs[k].name);

    // 6: async reset while ch3 filter count is 1
    step(4'hA, 0, 4'h2, 4'h0, "ar_e0");
    step(4'hA, 0, 4'h2, 4'h0, "ar_e1");
    step(4'hA, 0, 4'h2, 4'h0, "ar_e2");
    #2;
    rst_b = 1'b0;
    #1;
    check("ar_immediate", 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check("ar_held", 4'h0, 4'h0);
    rst_b = 1'b1;
    for (int k = 0; k < 4; k++) step(4'hA, 0, 4'h0, 4'h0, "ar_resync_wait");
    step(4'hA, 0, 4'hA, 4'hA, "ar_resync_accept");
    step(4'hA, 0, 4'hA, 4'h0, "ar_resync_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
